mips_fetch_queue: RTL and testbench
===================================

# mips_fetch_queue

Parametrised instruction-fetch front end for the MIPS core family. It replaces the combinational fetch unit with a decoupled prefetcher. It issues word-address requests to an instruction memory with variable latency and in-order responses, and buffers returned instructions with their PC in a DEPTH-entry queue. It delivers them to decode over a valid/ready handshake, and flushes cleanly on branch/jump redirects from execute.

## Interface
- ADDR_W, 30: word-address width; PC and memory addresses are word addresses (byte address = {PC, 2'b00}).
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: word address fetched first after reset.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- im_req  out  1  fetch request valid.
- im_addr  out  ADDR_W  fetch word address.
- im_ready  in  1  memory accepts request this cycle when im_req&im_ready.
- im_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- im_rdata  in  32  instruction word.
- ir_valid  out  1  queue head valid.
- ir_ready  in  1  decode consumes head when ir_valid&ir_ready.
- IR  out  32  head instruction.
- PC  out  ADDR_W  head instruction word address.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch word address.

## Operation
- State: fetch pointer fpc, queue (DEPTH × {IR, PC}), outstanding counter out_cnt, discard counter drop_cnt; counters are $clog2(DEPTH)+1 bits.
- Credit rule: im_req=1 iff count+out_cnt < DEPTH and redirect=0; every accepted response therefore has a free slot. A response never stalls.
- Accept (im_req&im_ready): fpc←fpc+1 (mod 2^ADDR_W, wraps silently), out_cnt+1.
- Response (im_rvalid): out_cnt−1. If drop_cnt>0, drop_cnt−1 and discard the word; otherwise push {im_rdata, PC tag}. PC tags come from a parallel tag queue written at accept.
- Pop on ir_valid&ir_ready; push and pop in the same cycle are both honoured.
- Redirect: queue emptied, fpc←redirect_pc, drop_cnt←(all in flight, including a response arriving this cycle), out_cnt keeps counting real returns. The head pop in the redirect cycle still counts as consumed. Redirect overrides any push in the same cycle.
- Simultaneous redirect on consecutive cycles: the last one wins; drop_cnt accumulates correctly.

## Timing
- Reset values: im_req=0, im_addr=RESET_PC, ir_valid=0, IR=0, PC=0, counters 0.
- First im_req=1 in the first cycle after reset deassertion.
- Response-to-ir_valid latency: 1 cycle (registered queue output).
- With 1-cycle memory, im_ready=1 and ir_ready=1, steady-state throughput is 1 instruction/cycle.
- After redirect at cycle t: im_addr=redirect_pc with im_req=1 at t+1 if credits allow; the first new instruction is on IR no earlier than t+3.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; in-flight responses after reset release are ignored only if memory is also reset. The memory shares the same reset.

## Configuration
- MIPS_FETCH_JPREDECODE_EN defined: a pushed word with opcode J (000010) or JAL (000011) acts as an internal redirect to {tagPC+1[ADDR_W-1:26], imm26} in the following cycle. The jump word itself is kept, and younger in-flight words are discarded. Execute may still assert redirect to the same target without harm.
- Undefined: no predecode; only the external redirect changes fpc.

## Structure
- Package mips_fetch_pkg: OP_J, OP_JAL opcode constants, opcode field slice positions, fetch entry struct {instr, pc}.
- Sub-module mips_fetch_fifo: parametrised DEPTH circular buffer with wrap pointers, count, push/pop/flush.

## Test plan
- Reset, 1-cycle memory, ir_ready=1: IR sequence is words at PC 0,1,2,3…; ir_valid continuous from cycle 3.
- ir_ready=0 with DEPTH=4: exactly 4 requests issued, then im_req=0; ir_valid stays 1 with PC=0.
- 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding: both stale responses dropped; next IR has PC=0x100.
- Redirect asserted in the same cycle as im_rvalid and a pop: response dropped, pop counted, queue empty at t+1.
- fpc=2^ADDR_W−1: next request im_addr=0.
- With MIPS_FETCH_JPREDECODE_EN: J imm26=0x40 at PC 8 gives next delivered PC=0x40, with PCs 9 and 10 never delivered; without the macro, PC 9 follows.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS decoupled instruction-fetch front end.
//
// Contents:
//   OP_J, OP_JAL     primary opcodes of the absolute jumps
//   OPC_HI/OPC_LO    opcode field position within an instruction word
//   IMM_HI/IMM_LO    26-bit jump index field position
//   fetch_entry_t    queue entry {instr, pc}; pc is held at its widest legal size and
//                    narrowed to the configured address width by the users
//   is_jump()        predecode helper for J/JAL
//
// Optional feature macro used by the fetch queue: MIPS_FETCH_JPREDECODE_EN.

package mips_fetch_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_MAX_W = 32;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned IMM_HI = 25;
    localparam int unsigned IMM_LO = 0;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef struct packed {
        logic [INSTR_W-1:0]  instr;
        logic [PC_MAX_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        logic [OPC_HI-OPC_LO:0] opc;
        opc = instr[OPC_HI:OPC_LO];
        return (opc == OP_J) || (opc == OP_JAL);
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Circular buffer used for both the instruction queue and the in-flight PC tag queue.
//
// Parameters:
//   DEPTH  number of entries, power of two, >= 2
//   WIDTH  entry width in bits
//
// Ports:
//   clk     clock, all state on rising edge
//   reset   asynchronous active-low reset
//   push    write wdata at the tail (ignored when full and not popping)
//   pop     drop the head entry (ignored when empty)
//   flush   empty the buffer; overrides a push in the same cycle
//   wdata   entry to write
//   rdata   head entry, forced to zero while empty
//   count   number of valid entries (0..DEPTH)

module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full buffer can still take a word if the head leaves in the same cycle.
    assign do_push = push && !flush && ((count_q != (PTR_W + 1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Only the occupancy matters after a flush; realign read to write.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/mips_fetch_queue.sv
// Decoupled instruction prefetcher for the MIPS core family.
//
// Issues word-address requests to an in-order, variable-latency instruction memory,
// buffers returned words with their PC in a DEPTH-entry queue and hands them to decode
// over a valid/ready handshake. Redirects from execute flush the queue and discard
// every response still in flight.
//
// Parameters:
//   ADDR_W    word-address width (byte address = {PC, 2'b00}), 26 < ADDR_W <= 32
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  first word address fetched after reset
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   im_req       fetch request valid
//   im_addr      fetch word address
//   im_ready     memory accepts the request this cycle
//   im_rvalid    response valid (in request order, >= 1 cycle after acceptance)
//   im_rdata     response instruction word
//   ir_valid     queue head valid
//   ir_ready     decode consumes the head
//   IR           head instruction (0 when empty)
//   PC           head word address (0 when empty)
//   redirect     flush and restart fetch
//   redirect_pc  restart word address
//
// Build option MIPS_FETCH_JPREDECODE_EN: a queued J/JAL word redirects fetch to its
// target on the following cycle, keeping the jump and discarding younger words.

module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 30,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic              im_rvalid,
    input  logic [31:0]       im_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       IR,
    output logic [ADDR_W-1:0] PC,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W:0]    credit_used;

    logic              jr_q;
    logic [ADDR_W-1:0] jr_target_q;

    logic              kill;
    logic              accept;
    logic              resp_drop;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] tag_pc;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // External redirect or a predecoded jump: stop issuing and retire everything in
    // flight as stale. Only the external one empties the queue.
    assign kill = redirect || jr_q;

    // Every queued or in-flight word owns a slot, so a response can always be taken.
    assign credit_used = {1'b0, q_count} + {1'b0, out_cnt};
    assign im_req      = reset && !kill && (credit_used < (CNT_W + 1)'(DEPTH));
    assign im_addr     = fpc_q;
    assign accept      = im_req && im_ready;

    assign resp_drop = (drop_cnt_q != '0);
    assign push      = im_rvalid && !resp_drop && !kill;
    assign pop       = ir_valid && ir_ready;

    // Tag queue: PC of every accepted request, retired by responses in order. Its
    // occupancy is exactly the number of requests in flight.
    mips_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (im_rvalid),
        .flush (1'b0),
        .wdata (fpc_q),
        .rdata (tag_pc),
        .count (out_cnt)
    );

    always_comb begin
        push_entry       = '0;
        push_entry.instr = im_rdata;
        push_entry.pc    = PC_MAX_W'(tag_pc);
    end

    mips_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (q_count)
    );

    assign ir_valid = (q_count != '0);
    assign IR       = head_entry.instr;
    assign PC       = ADDR_W'(head_entry.pc);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (kill) begin
            // A response arriving now is discarded by the kill itself; the rest are
            // still on their way. No request is accepted in this cycle.
            drop_cnt_d = out_cnt - CNT_W'(im_rvalid);
        end else if (im_rvalid && resp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        fpc_d = fpc_q;
        if (redirect) begin
            fpc_d = redirect_pc;
        end else if (jr_q) begin
            fpc_d = jr_target_q;
        end else if (accept) begin
            fpc_d = fpc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef MIPS_FETCH_JPREDECODE_EN
    logic              jr_d;
    logic [ADDR_W-1:0] jr_target_d;

    // Jump target keeps the upper bits of the delay-slot PC (tag + 1).
    always_comb begin
        jr_d                        = push && is_jump(im_rdata);
        jr_target_d                 = tag_pc + ADDR_W'(1);
        jr_target_d[IMM_HI:IMM_LO] = im_rdata[IMM_HI:IMM_LO];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jr_q        <= 1'b0;
            jr_target_q <= '0;
        end else begin
            jr_q        <= jr_d;
            jr_target_q <= jr_target_d;
        end
    end
`else
    assign jr_q        = 1'b0;
    assign jr_target_q = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
module tb_mips_fetch_queue;

    logic        clk;
    logic        reset;
    logic        im_req;
    logic [29:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] IR;
    logic [29:0] PC;
    logic        redirect;
    logic [29:0] redirect_pc;

    int total;
    int bad;
    int cyc;
    int lat;
    int acc_cnt;
    bit jtest;

    logic [29:0] pend_addr[$];
    int          pend_due[$];
    logic [29:0] del_pc[$];
    logic [31:0] del_ir[$];

`ifdef MIPS_FETCH_JPREDECODE_EN
    localparam bit JPRE = 1'b1;
`else
    localparam bit JPRE = 1'b0;
`endif

    mips_fetch_queue #(
        .ADDR_W   (30),
        .DEPTH    (4),
        .RESET_PC (30'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .IR          (IR),
        .PC          (PC),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [29:0] a);
        if (jtest && a == 30'd8) return 32'h0800_0040;
        return {8'h3C, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the in-order memory model; returns just after the falling edge.
    task automatic tick();
        int          nxt;
        logic        rv;
        logic        acc;
        logic [29:0] acc_addr;
        nxt = cyc + 1;
        rv  = (pend_addr.size() != 0) && (pend_due[0] <= nxt);
        im_rvalid = rv;
        im_rdata  = rv ? word(pend_addr[0]) : 32'h0;
        im_ready  = 1'b1;
        #1;
        acc      = im_req && im_ready;
        acc_addr = im_addr;
        if (ir_valid && ir_ready) begin
            del_pc.push_back(PC);
            del_ir.push_back(IR);
        end
        @(posedge clk);
        cyc = nxt;
        if (rv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(acc_addr);
            pend_due.push_back(cyc + lat);
            acc_cnt++;
        end
        #1;
        redirect  = 1'b0;
        im_rvalid = 1'b0;
        im_rdata  = 32'h0;
        @(negedge clk);
    endtask

    // Asynchronous reset of DUT and memory model together.
    task automatic do_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        im_rvalid = 1'b0;
        #1;
        chk("rst_im_req", im_req, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_IR", IR, 0);
        chk("rst_PC", PC, 0);
        pend_addr.delete();
        pend_due.delete();
        del_pc.delete();
        del_ir.delete();
        acc_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_im_req", im_req, 1);
    endtask

    initial begin
        int idx;
        int n910;
        clk = 0; reset = 0; im_ready = 1; im_rvalid = 0; im_rdata = 0;
        ir_ready = 1; redirect = 0; redirect_pc = 0;
        total = 0; bad = 0; cyc = 0; lat = 1; acc_cnt = 0; jtest = 0;
        @(negedge clk);

        // Streaming with 1-cycle memory.
        do_reset();
        tick();
        chk("t1_valid_c1", ir_valid, 0);
        chk("t1_addr_c1", im_addr, 1);
        tick();
        chk("t1_valid_c2", ir_valid, 1);
        chk("t1_pc_c2", PC, 0);
        chk("t1_ir_c2", IR, word(30'd0));
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk("t1_valid", ir_valid, 1);
            chk("t1_pc", PC, 64'(k - 2));
            chk("t1_ir", IR, word(30'(k - 2)));
        end
        chk("t1_ndel", del_pc.size(), 6);
        chk("t1_del5", del_pc[5], 5);

        // Backpressure: credits stop issue at DEPTH (reset taken mid-stream).
        ir_ready = 0;
        do_reset();
        repeat (8) tick();
        chk("t2_accepts", acc_cnt, 4);
        chk("t2_im_req", im_req, 0);
        chk("t2_valid", ir_valid, 1);
        chk("t2_pc", PC, 0);
        chk("t2_ir", IR, word(30'd0));
        chk("t2_ndel", del_pc.size(), 0);
        ir_ready = 1;

        // Redirect with two requests outstanding, 3-cycle memory.
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect = 1; redirect_pc = 30'h100;
        tick();
        chk("t3_addr", im_addr, 30'h100);
        chk("t3_req", im_req, 1);
        tick();
        chk("t3_valid_a", ir_valid, 0);
        tick();
        chk("t3_valid_b", ir_valid, 0);
        tick();
        chk("t3_valid_c", ir_valid, 0);
        tick();
        chk("t3_valid_d", ir_valid, 1);
        chk("t3_pc", PC, 30'h100);
        chk("t3_ir", IR, word(30'h100));
        chk("t3_ndel", del_pc.size(), 0);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        tick();
        tick();
        chk("t4_pc0", PC, 0);
        redirect = 1; redirect_pc = 30'h200;
        tick();
        chk("t4_empty", ir_valid, 0);
        chk("t4_ndel", del_pc.size(), 1);
        chk("t4_delpc", del_pc[0], 0);
        chk("t4_addr", im_addr, 30'h200);
        tick();
        tick();
        chk("t4_valid", ir_valid, 1);
        chk("t4_pc", PC, 30'h200);

        // Back-to-back redirects: last one wins.
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect = 1; redirect_pc = 30'h300;
        tick();
        redirect = 1; redirect_pc = 30'h400;
        tick();
        chk("t5_addr", im_addr, 30'h400);
        tick();
        chk("t5_valid_a", ir_valid, 0);
        tick();
        tick();
        chk("t5_valid_b", ir_valid, 0);
        tick();
        chk("t5_valid_c", ir_valid, 1);
        chk("t5_pc", PC, 30'h400);

        // Fetch pointer wrap.
        lat = 1;
        do_reset();
        redirect = 1; redirect_pc = 30'h3FFF_FFFF;
        tick();
        chk("t6_addr_top", im_addr, 30'h3FFF_FFFF);
        chk("t6_req", im_req, 1);
        tick();
        chk("t6_addr_wrap", im_addr, 0);
        tick();
        chk("t6_valid", ir_valid, 1);
        chk("t6_pc_top", PC, 30'h3FFF_FFFF);
        chk("t6_ir_top", IR, 32'h3CFF_FFFF);
        tick();
        chk("t6_pc_zero", PC, 0);

        // J at PC 8 (imm26 = 0x40).
        jtest = 1;
        do_reset();
        repeat (16) tick();
        idx = -1;
        n910 = 0;
        for (int i = 0; i < del_pc.size(); i++) begin
            if (idx < 0 && del_pc[i] == 30'd8) idx = i;
            if (del_pc[i] == 30'd9 || del_pc[i] == 30'd10) n910++;
        end
        chk("t7_found", (idx >= 0 && idx + 1 < del_pc.size()), 1);
        if (idx >= 0 && idx + 1 < del_pc.size()) begin
            chk("t7_jump_ir", del_ir[idx], 32'h0800_0040);
            chk("t7_next_pc", del_pc[idx + 1], JPRE ? 64'h40 : 64'h9);
        end
        chk("t7_n9_10", n910, JPRE ? 0 : 2);
        jtest = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
